conv_result_writer: RTL and testbench

- Downstream stage of the convolution unit. Consumes its one-cycle result pulses (valid + 32-bit data) and stores each result to memory at out_base + 4*index through an LSU write port.
- The conv unit cannot be back-pressured, so a small FIFO absorbs LSU latency.
- Configured by the same CUSTOM0 issue interface (funct3=011, SETOUT). Reports busy, done, overflow and a results-written count.

---
 rtl/conv_result_writer_if.sv | 31 +++
 rtl/conv_result_writer.sv | 81 ++++++++
 tb/tb_conv_result_writer.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_result_writer_if.sv
// conv_result_writer_if: issue, result-pulse, memory-write and status signals of the conv result writer
// Ports:
//   opcode_valid, opcode, opcode_invalid, ra, rb : CUSTOM0 issue bus (ra = out base, rb[CNT_W-1:0] = N)
//   res_valid, res_data                          : one-cycle result pulses from the conv unit
//   mem_wr, mem_addr, mem_data, mem_ack          : LSU write port, held until acked
//   busy, done, overflow, count                  : status
interface conv_result_writer_if #(parameter int CNT_W = 16);
  logic opcode_valid;
  logic [31:0] opcode;
  logic opcode_invalid;
  logic [31:0] ra;
  logic [31:0] rb;
  logic res_valid;
  logic [31:0] res_data;
  logic mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic mem_ack;
  logic busy;
  logic done;
  logic overflow;
  logic [CNT_W-1:0] count;
  modport master (
    output opcode_valid, opcode, opcode_invalid, ra, rb, res_valid, res_data, mem_ack,
    input mem_wr, mem_addr, mem_data, busy, done, overflow, count
  );
  modport slave (
    input opcode_valid, opcode, opcode_invalid, ra, rb, res_valid, res_data, mem_ack,
    output mem_wr, mem_addr, mem_data, busy, done, overflow, count
  );
endinterface

// File: rtl/conv_result_writer.sv
// conv_result_writer: buffers conv result pulses in a FIFO and writes each to out_base + 4*index
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-low reset
//   bus   : conv_result_writer_if.slave (issue bus, result pulses, LSU write port, status)
module conv_result_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W = 16
) (
  input logic clk_i,
  input logic rst_i,
  conv_result_writer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;
  state_t state;
  logic [31:0] fifo [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [CNT_W-1:0] n, rx_cnt, wr_cnt, idx;
  logic [31:0] base, addr, data;
  logic wr, ovf, setout, armed, empty, full, ack, pop, push;
  logic unused;
  assign unused = ^{bus.rb[31:CNT_W], bus.ra[1:0], bus.opcode[31:15], bus.opcode[11:7]};
  assign setout = bus.opcode_valid && !bus.opcode_invalid && bus.opcode[6:0] == 7'b0001011 && bus.opcode[14:12] == 3'b011;
  assign armed = state == ARMED;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign ack = wr && bus.mem_ack;
  // the output register reloads whenever it is free or being released this cycle
  assign pop = !empty && (!wr || ack);
  // a full FIFO still accepts when the head leaves on the same edge
  assign push = armed && bus.res_valid && rx_cnt < n && (!full || pop);
  // index of the write being loaded: acked writes count before the next one is addressed
  assign idx = wr_cnt + CNT_W'(ack);
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      n <= '0;
      rx_cnt <= '0;
      wr_cnt <= '0;
      base <= '0;
      addr <= '0;
      data <= '0;
      wr <= 1'b0;
      ovf <= 1'b0;
    end else if (setout && !armed) begin
      base <= {bus.ra[31:2], 2'b00};
      n <= bus.rb[CNT_W-1:0];
      rx_cnt <= '0;
      wr_cnt <= '0;
      ovf <= 1'b0;
      wp <= '0;
      rp <= '0;
      state <= bus.rb[CNT_W-1:0] != '0 ? ARMED : IDLE;
    end else begin
      if (push) begin
        fifo[wp[AW-1:0]] <= bus.res_data;
        wp <= wp + 1'b1;
        rx_cnt <= rx_cnt + 1'b1;
      end
      if (armed && bus.res_valid && !push) ovf <= 1'b1;
      if (ack) wr_cnt <= idx;
      if (ack && idx == n) state <= DONE;
      if (pop) begin
        rp <= rp + 1'b1;
        wr <= 1'b1;
        addr <= base + (32'(idx) << 2);
        data <= fifo[rp[AW-1:0]];
      end else if (ack) wr <= 1'b0;
    end
  end
  assign bus.mem_wr = wr;
  assign bus.mem_addr = addr;
  assign bus.mem_data = data;
  assign bus.busy = state == ARMED;
  assign bus.done = state == DONE;
  assign bus.overflow = ovf;
  assign bus.count = wr_cnt;
endmodule

// File: tb/tb_conv_result_writer.sv
// tb_conv_result_writer: randomized and directed self-checking bench for conv_result_writer
module tb_conv_result_writer;
  localparam int DEPTH = 8;
  localparam logic [31:0] SETOUT_OP = {17'd0, 3'b011, 5'd0, 7'b0001011};
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int c;
  } wr_t;
  logic clk = 0;
  logic rst = 0;
  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int ack_mode = 0;
  logic pw = 0;
  logic seen = 0;
  logic [31:0] sentinel = 32'hFFFF_FFFF;
  wr_t got[$];
  conv_result_writer_if #(.CNT_W(16)) bus();
  conv_result_writer #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.mem_wr && bus.mem_ack) got.push_back('{bus.mem_addr, bus.mem_data, cyc});
    if (bus.mem_wr && bus.mem_data == sentinel) seen = 1;
  end
  // ack modes: 0 low, 1 high, 2 random, 3 one cycle after each request
  initial forever begin
    @(posedge clk);
    #2;
    case (ack_mode)
      0: bus.mem_ack = 0;
      1: bus.mem_ack = 1;
      2: bus.mem_ack = 1'($urandom_range(0, 1));
      default: bus.mem_ack = bus.mem_wr && pw && !bus.mem_ack;
    endcase
    pw = bus.mem_wr;
  end

  task automatic step(int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 0;
    step(2);
    rst = 1;
    got.delete();
    seen = 0;
  endtask

  task automatic setout(logic [31:0] ra, logic [31:0] rb);
    bus.opcode_valid = 1;
    bus.opcode = SETOUT_OP;
    bus.ra = ra;
    bus.rb = rb;
    step(1);
    bus.opcode_valid = 0;
  endtask

  task automatic pulse(logic [31:0] d);
    bus.res_valid = 1;
    bus.res_data = d;
    step(1);
    bus.res_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.mem_wr, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.overflow, bus.count} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: wr=%b addr=%h data=%h busy=%b done=%b ovf=%b cnt=%0d, required all 0",
               bus.mem_wr, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.overflow, bus.count);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_d[3] = '{32'h11, 32'h22, 32'h33};
    do_reset();
    ack_mode = 3;
    setout(32'h1000, 3);
    checks++;
    if (bus.busy !== 1'b1) begin errs++; $display("FAIL basic_busy: got %b need 1", bus.busy); end
    for (int i = 0; i < 3; i++) begin
      pulse(exp_d[i]);
      step(3);
    end
    for (int t = 0; t < 20 && !bus.done; t++) step(1);
    checks++;
    if (got.size() != 3) begin errs++; $display("FAIL basic_nwrites: got %0d need 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i].a !== 32'h1000 + 32'(4 * i) || got[i].d !== exp_d[i]) begin
        errs++;
        $display("FAIL basic_write%0d: got (%h,%h) need (%h,%h)", i, got[i].a, got[i].d, 32'h1000 + 32'(4 * i), exp_d[i]);
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 16'd3 || bus.overflow !== 1'b0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL basic_status: done=%b cnt=%0d ovf=%b busy=%b need 1,3,0,0", bus.done, bus.count, bus.overflow, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ack_mode = 1;
    setout(32'h4000, 4);
    for (int i = 0; i < 4; i++) pulse(32'hB0 + 32'(i));
    step(4);
    checks++;
    if (got.size() != 4) begin errs++; $display("FAIL b2b_nwrites: got %0d need 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      checks++;
      if (got[i].a !== 32'h4000 + 32'(4 * i) || got[i].d !== 32'hB0 + 32'(i) || got[i].c != got[0].c + i) begin
        errs++;
        $display("FAIL b2b_write%0d: got (%h,%h,cyc+%0d) need (%h,%h,cyc+%0d)", i, got[i].a, got[i].d,
                 got[i].c - got[0].c, 32'h4000 + 32'(4 * i), 32'hB0 + 32'(i), i);
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.count !== 16'd4) begin
      errs++;
      $display("FAIL b2b_status: done=%b cnt=%0d need 1,4", bus.done, bus.count);
    end
  endtask

  task automatic test_overflow();
    int kept;
    do_reset();
    ack_mode = 0;
    setout(32'h8000, 12);
    for (int i = 0; i < 12; i++) pulse(32'(i + 1));
    step(2);
    checks++;
    if (bus.overflow !== 1'b1 || bus.mem_wr !== 1'b1 || got.size() != 0) begin
      errs++;
      $display("FAIL ovf_stalled: ovf=%b wr=%b writes=%0d need 1,1,0", bus.overflow, bus.mem_wr, got.size());
    end
    ack_mode = 1;
    step(15);
    kept = DEPTH + 1;
    checks++;
    if (got.size() != kept) begin errs++; $display("FAIL ovf_nwrites: got %0d need %0d", got.size(), kept); end
    for (int i = 0; i < kept && i < got.size(); i++) begin
      checks++;
      if (got[i].a !== 32'h8000 + 32'(4 * i) || got[i].d !== 32'(i + 1)) begin
        errs++;
        $display("FAIL ovf_write%0d: got (%h,%h) need (%h,%h)", i, got[i].a, got[i].d, 32'h8000 + 32'(4 * i), 32'(i + 1));
      end
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.count !== 16'(kept) || bus.overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf_status: busy=%b done=%b cnt=%0d ovf=%b need 1,0,%0d,1", bus.busy, bus.done, bus.count, bus.overflow, kept);
    end
  endtask

  task automatic test_excess();
    do_reset();
    ack_mode = 1;
    sentinel = 32'h333;
    setout(32'hA000, 2);
    pulse(32'h111);
    pulse(32'h222);
    pulse(32'h333);
    step(6);
    checks++;
    if (got.size() != 2 || got[0].d !== 32'h111 || got[1].d !== 32'h222 || got[1].a !== 32'hA004) begin
      errs++;
      $display("FAIL excess_writes: n=%0d, need 2 writes (A000,111),(A004,222)", got.size());
    end
    checks++;
    if (bus.overflow !== 1'b1 || bus.done !== 1'b1 || seen !== 1'b0 || bus.count !== 16'd2) begin
      errs++;
      $display("FAIL excess_status: ovf=%b done=%b seen3rd=%b cnt=%0d need 1,1,0,2", bus.overflow, bus.done, seen, bus.count);
    end
    sentinel = 32'hFFFF_FFFF;
  endtask

  task automatic test_config();
    do_reset();
    ack_mode = 1;
    setout(32'h2003, 1);
    pulse(32'h55);
    step(4);
    checks++;
    if (got.size() != 1 || got[0].a !== 32'h2000 || bus.done !== 1'b1) begin
      errs++;
      $display("FAIL cfg_align: n=%0d addr=%h done=%b need 1,2000,1", got.size(), got.size() ? got[0].a : 32'h0, bus.done);
    end
    setout(32'h9000, 0);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.count !== 16'd0) begin
      errs++;
      $display("FAIL cfg_n0: busy=%b done=%b cnt=%0d need 0,0,0", bus.busy, bus.done, bus.count);
    end
    got.delete();
    setout(32'h3000, 2);
    setout(32'h5000, 5);
    pulse(32'h61);
    pulse(32'h62);
    step(4);
    checks++;
    if (got.size() != 2 || got[0].a !== 32'h3000 || got[1].a !== 32'h3004 || bus.done !== 1'b1 || bus.count !== 16'd2) begin
      errs++;
      $display("FAIL cfg_ignore_armed: n=%0d done=%b cnt=%0d need 2 writes at 3000/3004, 1, 2", got.size(), bus.done, bus.count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ack_mode = 0;
    setout(32'h6000, 3);
    pulse(32'h77);
    step(1);
    checks++;
    if (bus.mem_wr !== 1'b1) begin errs++; $display("FAIL rstmid_pre: wr=%b need 1", bus.mem_wr); end
    rst = 0;
    step(1);
    rst = 1;
    checks++;
    if ({bus.mem_wr, bus.mem_addr, bus.mem_data, bus.busy, bus.done, bus.overflow, bus.count} !== '0) begin
      errs++;
      $display("FAIL rstmid_outputs: wr=%b addr=%h data=%h busy=%b cnt=%0d, required all 0",
               bus.mem_wr, bus.mem_addr, bus.mem_data, bus.busy, bus.count);
    end
    ack_mode = 1;
    pulse(32'h88);
    step(3);
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0 || got.size() != 0) begin
      errs++;
      $display("FAIL rstmid_ignore: wr=%b busy=%b ovf=%b writes=%0d need 0,0,0,0", bus.mem_wr, bus.busy, bus.overflow, got.size());
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int n, k;
      logic [31:0] base;
      logic [31:0] q[$];
      do_reset();
      ack_mode = 2;
      n = $urandom_range(1, DEPTH);
      k = $urandom_range(1, n);
      base = $urandom;
      setout(base, 32'(n));
      for (int j = 0; j < k; j++) begin
        q.push_back($urandom);
        pulse(q[j]);
        step($urandom_range(0, 2));
      end
      for (int t = 0; t < 300 && got.size() < k; t++) step(1);
      step(1);
      checks++;
      if (got.size() != k) begin errs++; $display("FAIL rnd%0d_nwrites: got %0d need %0d", it, got.size(), k); end
      for (int j = 0; j < k && j < got.size(); j++) begin
        checks++;
        if (got[j].a !== {base[31:2], 2'b00} + 32'(4 * j) || got[j].d !== q[j]) begin
          errs++;
          $display("FAIL rnd%0d_write%0d: got (%h,%h) need (%h,%h)", it, j, got[j].a, got[j].d, {base[31:2], 2'b00} + 32'(4 * j), q[j]);
        end
      end
      checks++;
      if (bus.overflow !== 1'b0 || bus.count !== 16'(k) || bus.done !== (k == n) || bus.busy !== (k != n)) begin
        errs++;
        $display("FAIL rnd%0d_status: ovf=%b cnt=%0d done=%b busy=%b need 0,%0d,%b,%b", it, bus.overflow, bus.count,
                 bus.done, bus.busy, k, k == n, k != n);
      end
    end
  endtask

  initial begin
    bus.opcode_valid = 0;
    bus.opcode = '0;
    bus.opcode_invalid = 0;
    bus.ra = '0;
    bus.rb = '0;
    bus.res_valid = 0;
    bus.res_data = '0;
    bus.mem_ack = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_excess();
    test_config();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
